// File: rtl/accum_pkg.sv
// Shared types and constants for the accumulator packing stage.
package accum_pkg;
    typedef logic [7:0] acc_t;

    localparam int ALIGN_BITS = 2;
    localparam int OVF_W      = 8;

    typedef enum logic {IDLE, FILL} pstate_t;
endpackage

// File: rtl/accum_fifo.sv
// DEPTH-entry synchronous FIFO holding packed words plus their partial flag.
module accum_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_partial,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         head_partial,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = DEPTH[AW:0];

    logic [DEPTH-1:0][W-1:0] mem;
    logic [DEPTH-1:0]        part;
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             occ;
    logic                    do_push, do_pop;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem    <= '0;
            part   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr]  <= push_data;
                part[wr_ptr] <= push_partial;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign head_data    = mem[rd_ptr];
    assign head_partial = part[rd_ptr];
    assign full         = (occ == FULL_OCC);
    assign empty        = (occ == '0);
endmodule

// File: rtl/accum_packer.sv
// Packs aligned accumulator bytes into BYTES-wide words and queues them
// toward the bus; flags misaligned input and counts words lost to a full FIFO.
import accum_pkg::*;

module accum_packer #(
    parameter int BYTES = 4,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*BYTES-1:0] out_data,
    output logic               out_partial,
    output logic               align_err,
    output logic [OVF_W-1:0]   ovf_count
);
    localparam int CW = $clog2(BYTES);

    pstate_t               state, state_nx;
    logic [CW-1:0]         count, count_nx;
    logic [BYTES-1:0][7:0] lanes, word;
    acc_t                  in_byte;
    logic                  aligned, misaligned, last, close;
    logic                  full, empty, pop, drop;

    assign in_byte    = in_data;
    assign aligned    = in_valid && (in_byte[ALIGN_BITS-1:0] == '0);
    assign misaligned = in_valid && !aligned;
    assign last       = aligned && (count == CW'(BYTES-1));
    // Flush with an aligned byte closes the word even from IDLE, after the byte lands.
    assign close      = last || (flush && (state == FILL || aligned));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        word     = lanes;
        if (aligned)
            word[count] = in_byte;
        if (close) begin
            state_nx = IDLE;
            count_nx = '0;
        end else if (aligned) begin
            state_nx = FILL;
            count_nx = count + 1'b1;
        end
    end

    // Lanes are cleared on close so unused lanes of a flushed word read zero.
    always_ff @(posedge clk) begin
        if (reset || close)
            lanes <= '0;
        else
            lanes <= word;
    end

    assign pop  = out_valid && out_ready;
    assign drop = close && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            align_err <= 1'b0;
            ovf_count <= '0;
        end else begin
            if (misaligned)
                align_err <= 1'b1;
            if (drop && ovf_count != '1)
                ovf_count <= ovf_count + 1'b1;
        end
    end

    accum_fifo #(.W(8*BYTES), .DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (close),
        .push_data    (word),
        .push_partial (!last),
        .pop          (pop),
        .head_data    (out_data),
        .head_partial (out_partial),
        .full         (full),
        .empty        (empty)
    );

    assign out_valid = !empty;
endmodule

// File: tb/tb_accum_packer.sv
// Bench for accum_packer: directed table, corner sequences and random traffic
// against a queue-based model of packing, buffering and error accounting.
module tb_accum_packer;
    localparam int B = 4;
    localparam int D = 4;

    logic           clk = 0;
    logic           reset = 1;
    logic           in_valid = 0;
    logic [7:0]     in_data = 0;
    logic           flush = 0;
    logic           out_ready = 0;
    logic           out_valid;
    logic [8*B-1:0] out_data;
    logic           out_partial;
    logic           align_err;
    logic [7:0]     ovf_count;

    accum_packer #(.BYTES(B), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_partial(out_partial),
        .align_err(align_err), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit [8*B-1:0] d;
        bit           p;
    } mword_t;

    bit [7:0] mbytes[$];
    mword_t   mq[$];
    bit       merr;
    int       movf;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mbytes.delete();
        mq.delete();
        merr = 0;
        movf = 0;
    endtask

    task automatic model_step(input bit iv, input bit [7:0] d, input bit fl, input bit rdy);
        bit pop, close;
        mword_t w;
        pop = rdy && (mq.size() > 0);
        close = 0;
        if (iv && d[1:0] != 0) merr = 1;
        else if (iv) mbytes.push_back(d);
        if (mbytes.size() == B || (fl && mbytes.size() > 0)) begin
            close = 1;
            w.d = '0;
            foreach (mbytes[i]) w.d[i*8 +: 8] = mbytes[i];
            w.p = (mbytes.size() < B);
            mbytes.delete();
        end
        if (pop) void'(mq.pop_front());
        if (close) begin
            if (mq.size() < D) mq.push_back(w);
            else if (movf < 255) movf++;
        end
    endtask

    task automatic model_cmp();
        chk("m_valid", 64'(out_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("m_data", 64'(out_data), 64'(mq[0].d));
            chk("m_partial", 64'(out_partial), 64'(mq[0].p));
        end
        chk("m_align_err", 64'(align_err), 64'(merr));
        chk("m_ovf", 64'(ovf_count), 64'(movf));
    endtask

    task automatic cyc(input bit iv, input bit [7:0] d, input bit fl, input bit rdy);
        in_valid = iv; in_data = d; flush = fl; out_ready = rdy;
        model_step(iv, d, fl, rdy);
        @(posedge clk); #1;
        model_cmp();
    endtask

    task automatic do_reset();
        reset = 1; in_valid = 0; in_data = 0; flush = 0; out_ready = 0;
        @(posedge clk); #1;
        reset = 0;
        model_clear();
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_data", 64'(out_data), 0);
        chk("rst_partial", 64'(out_partial), 0);
        chk("rst_align_err", 64'(align_err), 0);
        chk("rst_ovf", 64'(ovf_count), 0);
    endtask

    function automatic bit [7:0] bval(input int k, input int j);
        return 8'(k * 16 + j * 4 + 4);
    endfunction

    function automatic bit [8*B-1:0] wexp(input int k);
        bit [8*B-1:0] w;
        for (int j = 0; j < B; j++) w[j*8 +: 8] = bval(k, j);
        return w;
    endfunction

    typedef struct {
        bit           iv;
        bit [7:0]     d;
        bit           fl;
        bit           rdy;
        bit           ev;
        bit [8*B-1:0] ed;
        bit           ep;
        bit           ee;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // inputs, then expected outputs after the edge
        tbl[0]  = '{1, 8'h04, 0, 0, 0, 32'h0, 0, 0};
        tbl[1]  = '{1, 8'h08, 0, 0, 0, 32'h0, 0, 0};
        tbl[2]  = '{1, 8'h0C, 0, 0, 0, 32'h0, 0, 0};
        tbl[3]  = '{1, 8'h10, 0, 0, 1, 32'h100C0804, 0, 0};
        tbl[4]  = '{0, 8'h00, 0, 1, 0, 32'h0, 0, 0};
        tbl[5]  = '{1, 8'h04, 0, 0, 0, 32'h0, 0, 0};
        tbl[6]  = '{1, 8'h03, 0, 0, 0, 32'h0, 0, 1};
        tbl[7]  = '{1, 8'h08, 0, 0, 0, 32'h0, 0, 1};
        tbl[8]  = '{1, 8'h0C, 0, 0, 0, 32'h0, 0, 1};
        tbl[9]  = '{1, 8'h10, 0, 0, 1, 32'h100C0804, 0, 1};
        tbl[10] = '{0, 8'h00, 0, 1, 0, 32'h0, 0, 1};
        tbl[11] = '{1, 8'h14, 0, 0, 0, 32'h0, 0, 1};
        tbl[12] = '{1, 8'h18, 0, 0, 0, 32'h0, 0, 1};
        tbl[13] = '{0, 8'h00, 1, 0, 1, 32'h00001814, 1, 1};
        tbl[14] = '{0, 8'h00, 1, 1, 0, 32'h0, 0, 1};
        tbl[15] = '{0, 8'h00, 0, 0, 0, 32'h0, 0, 1};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].iv, tbl[i].d, tbl[i].fl, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_err", i), 64'(align_err), 64'(tbl[i].ee));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_data", i), 64'(out_data), 64'(tbl[i].ed));
                chk($sformatf("tbl%0d_partial", i), 64'(out_partial), 64'(tbl[i].ep));
            end
        end

        // overflow: six words into a four-deep FIFO with no consumer
        do_reset();
        for (int k = 0; k < 6; k++)
            for (int j = 0; j < B; j++) cyc(1, bval(k, j), 0, 0);
        chk("ovf_two", 64'(ovf_count), 2);
        chk("ovf_head", 64'(out_data), 64'(32'h100C0804));
        // stall stability
        cyc(0, 0, 0, 0);
        chk("stall_head", 64'(out_data), 64'(32'h100C0804));
        // full FIFO: last byte of a new word arrives alongside a pop
        for (int j = 0; j < B - 1; j++) cyc(1, bval(6, j), 0, 0);
        cyc(1, bval(6, B - 1), 0, 1);
        chk("fullpop_ovf", 64'(ovf_count), 2);
        chk("fullpop_head", 64'(out_data), 64'(wexp(1)));
        cyc(0, 0, 0, 1);
        chk("drain1", 64'(out_data), 64'(wexp(2)));
        cyc(0, 0, 0, 1);
        chk("drain2", 64'(out_data), 64'(wexp(3)));
        cyc(0, 0, 0, 1);
        chk("drain3", 64'(out_data), 64'(wexp(6)));
        chk("drain3_valid", 64'(out_valid), 1);
        cyc(0, 0, 0, 1);
        chk("drain_empty", 64'(out_valid), 0);

        // reset with a partial word and a full queue
        do_reset();
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < B; j++) cyc(1, bval(k, j), 0, 0);
        cyc(1, bval(7, 0), 0, 0);
        cyc(1, bval(7, 1), 0, 0);
        chk("pre_rst_ovf", 64'(ovf_count), 1);
        cyc(1, 8'h01, 0, 0);
        chk("pre_rst_err", 64'(align_err), 1);
        do_reset();
        for (int j = 0; j < B; j++) cyc(1, bval(8, j), 0, 0);
        chk("post_rst_word", 64'(out_data), 64'(wexp(8)));
        chk("post_rst_partial", 64'(out_partial), 0);

        // flush alongside bytes: aligned byte joins the word, misaligned is dropped
        do_reset();
        cyc(1, 8'h20, 0, 0);
        cyc(1, 8'h24, 0, 0);
        cyc(1, 8'h28, 0, 0);
        cyc(1, 8'h2C, 1, 0);
        chk("fl_full_partial", 64'(out_partial), 0);
        chk("fl_full_data", 64'(out_data), 64'(32'h2C282420));
        cyc(1, 8'h30, 0, 1);
        cyc(1, 8'h31, 1, 0);
        chk("fl_mis_data", 64'(out_data), 64'(32'h00000030));
        chk("fl_mis_partial", 64'(out_partial), 1);
        chk("fl_mis_err", 64'(align_err), 1);

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit [7:0] d;
            bit iv, fl, rdy;
            d   = 8'($urandom);
            if ($urandom_range(0, 9) != 0) d[1:0] = 2'b00;
            iv  = ($urandom_range(0, 9) < 7);
            fl  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < (n < 1500 ? 3 : 7));
            cyc(iv, d, fl, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
